// File: rtl/rtc_pkg.sv
// Shared RTC types: timer state enum, BCD digit type and per-digit wrap limits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rtc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PAUSED = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_U_MAX = 4'd9;
    localparam bcd_t SEC_T_MAX = 4'd5;
    localparam bcd_t MIN_U_MAX = 4'd9;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit: parallel load, decrement enable, wraps 0 -> MAX.
// Latency: value updates on the edge after ld/dec; borrow_out is combinational (value == 0).
// Backpressure: none; ld overrides dec, no stall path.
module bcd_down_digit
    import rtc_pkg::*;
#(
    parameter bcd_t MAX = 4'd9
)
(
    input  logic clk,
    input  logic rst,
    input  logic ld,
    input  bcd_t ld_val,
    input  logic dec,
    output bcd_t value,
    output logic borrow_out
);

    // Digit register: load wins over decrement; a decrement at 0 wraps to MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (ld) begin
            value <= ld_val;
        end else if (dec) begin
            if (value == 4'd0) begin
                value <= MAX;
            end else begin
                value <= value - 4'd1;
            end
        end
    end

    // A decrement of this digit borrows from the next one up only when it sits at 0.
    assign borrow_out = (value == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with load/start/stop control and expiry/load-error pulses.
// Latency: every request takes effect on the next clk edge; event pulses are registered, 1 cycle.
// Backpressure: none; requests are 1-cycle strobes resolved load > stop > start > tick.
// Optional: define COUNTDOWN_AUTO_RELOAD_EN to reload from the last loaded value at expiry and keep running.
module countdown_timer
    import rtc_pkg::*;
#(
    parameter int MIN_TENS_MAX = 5
)
(
    input  logic       clk,
    input  logic       rset,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] ld_min_t,
    input  logic [3:0] ld_min_u,
    input  logic [3:0] ld_sec_t,
    input  logic [3:0] ld_sec_u,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] min_t,
    output logic [3:0] min_u,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic       running,
    output logic       done,
    output logic       expired,
    output logic       load_err
);

    localparam bcd_t MIN_T_MAX = bcd_t'(MIN_TENS_MAX);

    state_t state;
    state_t state_nxt;

    // Value captured on the last valid load; source for auto-reload.
    bcd_t rl_min_t;
    bcd_t rl_min_u;
    bcd_t rl_sec_t;
    bcd_t rl_sec_u;

    logic load_ok;
    logic load_take;
    logic reload_now;
    logic tick_en;
    logic expire_evt;
    logic load_err_evt;
    logic value_zero;
    logic value_one;

    logic bo_sec_u;
    logic bo_sec_t;
    logic bo_min_u;
    logic bo_min_t;

    logic dig_ld;
    bcd_t nx_min_t;
    bcd_t nx_min_u;
    bcd_t nx_sec_t;
    bcd_t nx_sec_u;

    // Range check on the incoming digits; one bad digit rejects the whole load.
    assign load_ok = (ld_sec_u <= SEC_U_MAX) && (ld_sec_t <= SEC_T_MAX) &&
                     (ld_min_u <= MIN_U_MAX) && (ld_min_t <= MIN_T_MAX);

    // Every digit at zero means every digit would borrow.
    assign value_zero = bo_sec_u & bo_sec_t & bo_min_u & bo_min_t;
    assign value_one  = bo_sec_t & bo_min_u & bo_min_t & (sec_u == 4'd1);

    // State register.
    always_ff @(posedge clk or posedge rset) begin
        if (rset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle controls; any load request consumes the cycle even if rejected.
    always_comb begin
        state_nxt    = state;
        load_take    = 1'b0;
        load_err_evt = 1'b0;
        tick_en      = 1'b0;
        expire_evt   = 1'b0;
        reload_now   = 1'b0;
        if (load) begin
            if (load_ok) begin
                load_take = 1'b1;
                state_nxt = ST_PAUSED;
            end else begin
                load_err_evt = 1'b1;
            end
        end else if (stop) begin
            if (state == ST_RUN) begin
                state_nxt = ST_PAUSED;
            end
        end else if (start && (state == ST_PAUSED) && !value_zero) begin
            state_nxt = ST_RUN;
        end else if (tick && (state == ST_RUN)) begin
            if (value_one) begin
                expire_evt = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                reload_now = 1'b1;
`else
                tick_en    = 1'b1;
                state_nxt  = ST_DONE;
`endif
            end else begin
                tick_en = 1'b1;
            end
        end
    end

    // Digit load source: external digits on a load, the reload register on auto-reload.
    assign dig_ld   = load_take | reload_now;
    assign nx_min_t = load_take ? ld_min_t : rl_min_t;
    assign nx_min_u = load_take ? ld_min_u : rl_min_u;
    assign nx_sec_t = load_take ? ld_sec_t : rl_sec_t;
    assign nx_sec_u = load_take ? ld_sec_u : rl_sec_u;

    bcd_down_digit #(.MAX(SEC_U_MAX)) u_sec_u (
        .clk(clk), .rst(rset), .ld(dig_ld), .ld_val(nx_sec_u),
        .dec(tick_en), .value(sec_u), .borrow_out(bo_sec_u)
    );

    bcd_down_digit #(.MAX(SEC_T_MAX)) u_sec_t (
        .clk(clk), .rst(rset), .ld(dig_ld), .ld_val(nx_sec_t),
        .dec(tick_en & bo_sec_u), .value(sec_t), .borrow_out(bo_sec_t)
    );

    bcd_down_digit #(.MAX(MIN_U_MAX)) u_min_u (
        .clk(clk), .rst(rset), .ld(dig_ld), .ld_val(nx_min_u),
        .dec(tick_en & bo_sec_u & bo_sec_t), .value(min_u), .borrow_out(bo_min_u)
    );

    bcd_down_digit #(.MAX(MIN_T_MAX)) u_min_t (
        .clk(clk), .rst(rset), .ld(dig_ld), .ld_val(nx_min_t),
        .dec(tick_en & bo_sec_u & bo_sec_t & bo_min_u), .value(min_t), .borrow_out(bo_min_t)
    );

    // Reload register follows every accepted load.
    always_ff @(posedge clk or posedge rset) begin
        if (rset) begin
            rl_min_t <= '0;
            rl_min_u <= '0;
            rl_sec_t <= '0;
            rl_sec_u <= '0;
        end else if (load_take) begin
            rl_min_t <= ld_min_t;
            rl_min_u <= ld_min_u;
            rl_sec_t <= ld_sec_t;
            rl_sec_u <= ld_sec_u;
        end
    end

    // Registered single-cycle event pulses; reset drops anything pending.
    always_ff @(posedge clk or posedge rset) begin
        if (rset) begin
            expired  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            expired  <= expire_evt;
            load_err <= load_err_evt;
        end
    end

    assign running = (state == ST_RUN);
    assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: load/start/stop/tick sequences with hand-computed values.
// Latency: inputs driven 1 ns after posedge, outputs sampled 1 ns after the following posedge.
// Backpressure: n/a.
module tb_countdown_timer;

    localparam int MTM = 5;

    logic       clk;
    logic       rset;
    logic       tick;
    logic       load;
    logic [3:0] ld_min_t;
    logic [3:0] ld_min_u;
    logic [3:0] ld_sec_t;
    logic [3:0] ld_sec_u;
    logic       start;
    logic       stop;
    logic [3:0] min_t;
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
    logic       running;
    logic       done;
    logic       expired;
    logic       load_err;

    int checks;
    int failures;

    countdown_timer #(.MIN_TENS_MAX(MTM)) dut (
        .clk(clk), .rset(rset), .tick(tick), .load(load),
        .ld_min_t(ld_min_t), .ld_min_u(ld_min_u), .ld_sec_t(ld_sec_t), .ld_sec_u(ld_sec_u),
        .start(start), .stop(stop),
        .min_t(min_t), .min_u(min_u), .sec_t(sec_t), .sec_u(sec_u),
        .running(running), .done(done), .expired(expired), .load_err(load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] disp();
        return {min_t, min_u, sec_t, sec_u};
    endfunction

    // Seconds remaining -> packed MM:SS BCD, e.g. 65 -> 16'h0105.
    function automatic logic [15:0] to_bcd(input int s);
        int m;
        int r;
        logic [3:0] a, b, c, d;
        m = s / 60;
        r = s % 60;
        a = 4'(m / 10);
        b = 4'(m % 10);
        c = 4'(r / 10);
        d = 4'(r % 10);
        return {a, b, c, d};
    endfunction

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1 ns after it, then drop all strobes.
    task automatic step();
        @(posedge clk);
        #1;
        tick  = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v);
        {ld_min_t, ld_min_u, ld_sec_t, ld_sec_u} = v;
        load = 1'b1;
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rset = 1'b1;
        tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
        {ld_min_t, ld_min_u, ld_sec_t, ld_sec_u} = 16'h0000;

        // Reset state, before any clock edge.
        #2;
        chk16("rst_digits", disp(), 16'h0000);
        chk1("rst_running", running, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_expired", expired, 1'b0);
        chk1("rst_load_err", load_err, 1'b0);
        @(negedge clk);
        rset = 1'b0;
        step();

        // Start in IDLE is ignored.
        start = 1'b1; step();
        chk1("idle_start_ignored", running, 1'b0);

        // 01:05 countdown over 65 ticks.
        do_load(16'h0105);
        chk16("load_0105", disp(), 16'h0105);
        chk1("load_0105_running", running, 1'b0);
        start = 1'b1; tick = 1'b1; step();
        chk1("start_running", running, 1'b1);
        chk16("start_no_dec", disp(), 16'h0105);
        for (int i = 1; i <= 65; i++) begin
            tick = 1'b1; step();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            chk16("cnt65_val", disp(), (i == 65) ? 16'h0105 : to_bcd(65 - i));
`else
            chk16("cnt65_val", disp(), to_bcd(65 - i));
`endif
            chk1("cnt65_expired", expired, (i == 65));
        end
`ifndef COUNTDOWN_AUTO_RELOAD_EN
        chk1("cnt65_done", done, 1'b1);
        chk1("cnt65_running", running, 1'b0);
        tick = 1'b1; step();
        chk1("done_expired_once", expired, 1'b0);
        chk16("done_hold", disp(), 16'h0000);
        start = 1'b1; step();
        chk1("done_start_ignored", running, 1'b0);
        chk1("done_still", done, 1'b1);
`else
        chk1("ar65_running", running, 1'b1);
        chk1("ar65_done", done, 1'b0);
        stop = 1'b1; step();
`endif

        // 10:00 borrow across all digits.
        do_load(16'h1000);
        chk1("load_1000_done_clr", done, 1'b0);
        start = 1'b1; step();
        tick = 1'b1; step();
        chk16("borrow_0959", disp(), 16'h0959);

        // 00:01 expires on one tick.
        do_load(16'h0001);
        start = 1'b1; step();
        tick = 1'b1; step();
        chk1("one_expired", expired, 1'b1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        chk16("one_reload", disp(), 16'h0001);
        chk1("one_running", running, 1'b1);
        stop = 1'b1; step();
`else
        chk16("one_zero", disp(), 16'h0000);
        chk1("one_done", done, 1'b1);
        step();
        chk1("one_expired_drop", expired, 1'b0);
`endif

        // Invalid loads leave digits and state untouched.
        do_load(16'h0010);
        chk1("err_base_load_err", load_err, 1'b0);
        do_load(16'h0060);
        chk1("err_sec_t_pulse", load_err, 1'b1);
        chk16("err_sec_t_digits", disp(), 16'h0010);
        step();
        chk1("err_sec_t_one_cycle", load_err, 1'b0);
        do_load(16'h6000);
        chk1("err_min_t_pulse", load_err, 1'b1);
        chk16("err_min_t_digits", disp(), 16'h0010);
        chk1("err_min_t_running", running, 1'b0);
        do_load(16'h5959);
        chk16("max_load_ok", disp(), 16'h5959);
        chk1("max_load_no_err", load_err, 1'b0);
        do_load(16'h0010);

        // Priority: stop beats start; accepted start swallows tick.
        start = 1'b1; stop = 1'b1; step();
        chk1("start_stop_paused", running, 1'b0);
        start = 1'b1; tick = 1'b1; step();
        chk1("start_tick_running", running, 1'b1);
        chk16("start_tick_hold", disp(), 16'h0010);
        tick = 1'b1; step();
        chk16("first_dec_0009", disp(), 16'h0009);

        // Stop holds digits; ticks while paused do nothing.
        stop = 1'b1; tick = 1'b1; step();
        chk1("stop_paused", running, 1'b0);
        chk16("stop_hold", disp(), 16'h0009);
        tick = 1'b1; step();
        chk16("paused_tick_ignored", disp(), 16'h0009);

        // Start at 00:00 is ignored.
        do_load(16'h0000);
        start = 1'b1; step();
        chk1("zero_start_ignored", running, 1'b0);

        // Asynchronous reset mid-run.
        do_load(16'h0030);
        start = 1'b1; step();
        chk1("pre_rst_running", running, 1'b1);
        #2;
        rset = 1'b1;
        #1;
        chk16("async_rst_digits", disp(), 16'h0000);
        chk1("async_rst_running", running, 1'b0);
        #1;
        rset = 1'b0;
        step();
        start = 1'b1; step();
        chk1("post_rst_start_ignored", running, 1'b0);
        chk16("post_rst_digits", disp(), 16'h0000);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // Auto-reload: two consecutive expiries from 00:02.
        do_load(16'h0002);
        start = 1'b1; step();
        tick = 1'b1; step();
        chk16("ar_0001", disp(), 16'h0001);
        tick = 1'b1; step();
        chk1("ar_exp1", expired, 1'b1);
        chk16("ar_reload", disp(), 16'h0002);
        chk1("ar_running", running, 1'b1);
        chk1("ar_done", done, 1'b0);
        tick = 1'b1; step();
        chk1("ar_exp_drop", expired, 1'b0);
        tick = 1'b1; step();
        chk1("ar_exp2", expired, 1'b1);
        chk16("ar_reload2", disp(), 16'h0002);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
